pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have parameter MAX_LD, default 2, maximum outstanding loads (1..8).
REQ-003 SHALL have parameter FLUSH_CYCLES, default 1, bubble cycles after a flush (1..15).
REQ-004 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  kill younger instructions this cycle.
REQ-007 SHALL have ports is_alu_op  input  1, and alu_rd  input  REG_ADDR_W, for an ALU result requesting writeback.
REQ-008 SHALL have ports is_ld_op  input  1, and ld_rd  input  REG_ADDR_W, for a load requesting issue.
REQ-009 SHALL have port ld_valid  input  1  in-order load data return.
REQ-010 SHALL have ports rs1, rs2  input  REG_ADDR_W, and rs1_used, rs2_used  input  1, for decode-stage sources.
REQ-011 SHALL have outputs fetch_stall 1, reg_we 1, reg_waddr REG_ADDR_W, wb_sel 1 (0 ALU, 1 load), lsu_en 1, alu_ack 1, ld_ack 1, ld_fwd 1, and ld_pending clog2(MAX_LD+1).

Function
REQ-012 SHALL hold a MAX_LD-deep in-order FIFO of destination addresses for outstanding loads.
REQ-013 SHALL assert ld_ack and push ld_rd when is_ld_op & ~flush & state==RUN & FIFO not full.
REQ-014 SHALL pop the FIFO head on ld_valid; the pop and a same-cycle push are both legal, including at full.
REQ-015 SHALL assert reg_we, wb_sel=1, reg_waddr=head on ld_valid in RUN when ~flush and head!=0.
REQ-016 SHALL, when no load write occurs, assert reg_we, wb_sel=0, reg_waddr=alu_rd, alu_ack on is_alu_op & ~flush & alu_rd!=0 in RUN.
REQ-017 SHALL give load writeback priority; a colliding ALU op gets alu_ack=0 and fetch_stall=1, and the source holds it.
REQ-018 SHALL drive fetch_stall as the OR of: RAW hazard (a used rs, nonzero, equals any valid FIFO entry), is_ld_op with FIFO full, ALU/load collision, or state!=RUN.
REQ-019 SHALL drive lsu_en = ~flush & state==RUN.
REQ-020 SHALL implement FSM RUN/DRAIN/BUBBLE.
REQ-021 SHALL, on flush with loads outstanding or returning, latch kill_cnt = ld_pending and enter DRAIN; with none outstanding, enter BUBBLE.
REQ-022 SHALL, in DRAIN, drop every ld_valid return (no reg_we), decrement kill_cnt, and move to BUBBLE when kill_cnt reaches 0.
REQ-023 SHALL, in BUBBLE, count FLUSH_CYCLES cycles, then return to RUN.
REQ-024 SHALL restart the BUBBLE count on a flush in BUBBLE, and ignore a flush in DRAIN since all entries are already killed.
REQ-025 SHALL drop a ld_valid coincident with flush, with no write.
REQ-026 SHALL treat ld_valid with an empty FIFO as a protocol error: ignored, no write, ld_pending stays 0.
REQ-027 SHALL have ld_pending equal the FIFO occupancy, registered.

Reset
REQ-028 SHALL, on reset, empty the FIFO, set state=RUN, and clear kill_cnt and the bubble counter.
REQ-029 SHALL drive all outputs to 0 while reset is high; reset mid-DRAIN/BUBBLE returns to RUN next cycle.

Configuration
REQ-030 SHALL support macro PIPE_CTRL_LD_FWD_EN.
  - Defined: a RAW hazard whose only match is the FIFO head returning this cycle (ld_valid) does not stall; ld_fwd=1 that cycle.
  - Undefined: that case stalls one extra cycle; ld_fwd is tied to 0.

Verification
REQ-031 SHALL verify load-use: load to x5, next cycle rs1=5 used -> fetch_stall=1 until the return cycle (with FWD_EN) or return+1 (without); reg_we=1 with waddr=5.
REQ-032 SHALL verify full: MAX_LD=2, issue 3 loads back-to-back with no return -> third gets ld_ack=0 and fetch_stall=1; ld_valid plus a load in the same cycle -> ld_ack=1 and ld_pending stays 2.
REQ-033 SHALL verify collision: is_alu_op with rd=7 and ld_valid with head rd=3 in the same cycle -> reg_waddr=3, wb_sel=1, alu_ack=0; next cycle reg_waddr=7, wb_sel=0.
REQ-034 SHALL verify flush drain: 2 loads outstanding then flush -> DRAIN; two ld_valid produce no reg_we; then FLUSH_CYCLES=3 bubble cycles with fetch_stall=1; then RUN.
REQ-035 SHALL verify x0: is_alu_op with alu_rd=0, and a load to rd 0 returning -> reg_we=0, and rs1=0 never stalls.
REQ-036 SHALL verify reset during DRAIN -> ld_pending=0 and state RUN; all outputs 0 while reset is high.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / writeback controller: tracks outstanding load destinations,
// arbitrates the register-file write port and sequences flush recovery.
// Optional macro PIPE_CTRL_LD_FWD_EN: lets a consumer of the returning head load proceed with ld_fwd=1.
module pipe_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int MAX_LD       = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          is_alu_op,
  input  logic [REG_ADDR_W-1:0]         alu_rd,
  input  logic                          is_ld_op,
  input  logic [REG_ADDR_W-1:0]         ld_rd,
  input  logic                          ld_valid,
  input  logic [REG_ADDR_W-1:0]         rs1,
  input  logic [REG_ADDR_W-1:0]         rs2,
  input  logic                          rs1_used,
  input  logic                          rs2_used,
  output logic                          fetch_stall,
  output logic                          reg_we,
  output logic [REG_ADDR_W-1:0]         reg_waddr,
  output logic                          wb_sel,
  output logic                          lsu_en,
  output logic                          alu_ack,
  output logic                          ld_ack,
  output logic                          ld_fwd,
  output logic [$clog2(MAX_LD+1)-1:0]   ld_pending,
  output logic [1:0]                    dbg_state
);

  localparam int CNT_W = $clog2(MAX_LD + 1);
  localparam int PTR_W = (MAX_LD > 1) ? $clog2(MAX_LD) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(MAX_LD - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [3:0]       BUB_INIT = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, BUBBLE = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        kill_q, kill_d;
  logic [3:0]              bub_q, bub_d;
  logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
  logic [MAX_LD-1:0]       vld_q;
  logic [REG_ADDR_W-1:0]   mem_q [MAX_LD];

  logic                    run, empty, full, pop, push, ld_ret, ld_wr, alu_req, alu_wr;
  logic                    hit_any, hit_young, m, raw_stall, fwd;
  logic [REG_ADDR_W-1:0]   head;
  logic [CNT_W-1:0]        remain;

  always_comb begin
    run     = (state_q == RUN);
    empty   = (cnt_q == '0);
    full    = (cnt_q == MAX_CNT);
    head    = mem_q[rd_ptr_q];
    pop     = ld_valid & ~empty;
    ld_ret  = pop & run & ~flush;
    ld_wr   = ld_ret & (head != '0);
    alu_req = is_alu_op & ~flush & run & (alu_rd != '0);
    alu_wr  = alu_req & ~ld_wr;
    // A pop in the same cycle frees the slot, so a load may issue even at full.
    push    = is_ld_op & ~flush & run & (~full | pop);
    remain  = cnt_q - CNT_W'(pop);

    hit_any   = 1'b0;
    hit_young = 1'b0;
    for (int i = 0; i < MAX_LD; i++) begin
      m = 1'b0;
      if (vld_q[i]) begin
        m = (rs1_used && rs1 != '0 && mem_q[i] == rs1) ||
            (rs2_used && rs2 != '0 && mem_q[i] == rs2);
      end
      hit_any = hit_any | m;
      if (!(ld_ret && PTR_W'(i) == rd_ptr_q)) hit_young = hit_young | m;
    end
`ifdef PIPE_CTRL_LD_FWD_EN
    raw_stall = hit_young;
    fwd       = hit_any & ~hit_young;
`else
    raw_stall = hit_any;
    fwd       = 1'b0;
`endif

    state_d = state_q;
    kill_d  = kill_q;
    bub_d   = bub_q;
    case (state_q)
      RUN: if (flush) begin
        // Count only loads still in flight after any return dropped this cycle.
        if (remain != '0) begin
          state_d = DRAIN;
          kill_d  = remain;
        end else begin
          state_d = BUBBLE;
          bub_d   = BUB_INIT;
        end
      end
      DRAIN: if (pop) begin
        kill_d = kill_q - CNT_ONE;
        if (kill_q == CNT_ONE) begin
          state_d = BUBBLE;
          bub_d   = BUB_INIT;
        end
      end
      BUBBLE: begin
        if (flush)              bub_d = BUB_INIT;
        else if (bub_q == 4'd0) state_d = RUN;
        else                    bub_d = bub_q - 4'd1;
      end
      default: state_d = RUN;
    endcase

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    fetch_stall = 1'b0;
    reg_we      = 1'b0;
    reg_waddr   = '0;
    wb_sel      = 1'b0;
    lsu_en      = 1'b0;
    alu_ack     = 1'b0;
    ld_ack      = 1'b0;
    ld_fwd      = 1'b0;
    ld_pending  = '0;
    dbg_state   = 2'd0;
    if (!reset) begin
      fetch_stall = raw_stall | (is_ld_op & full & ~pop) | (alu_req & ld_wr) | ~run;
      reg_we      = ld_wr | alu_wr;
      reg_waddr   = ld_wr ? head : (alu_wr ? alu_rd : '0);
      wb_sel      = ld_wr;
      lsu_en      = ~flush & run;
      alu_ack     = alu_wr;
      ld_ack      = push;
      ld_fwd      = fwd;
      ld_pending  = cnt_q;
      dbg_state   = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      kill_q   <= '0;
      bub_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      bub_q   <= bub_d;
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_ONE;
      end
      if (push) begin
        vld_q[wr_ptr_q] <= 1'b1;
        mem_q[wr_ptr_q] <= ld_rd;
        wr_ptr_q        <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (MAX_LD=2, FLUSH_CYCLES=3): inputs change on the
// falling edge, outputs are checked 1ns later, state advances on the rising edge.
module tb_pipe_ctrl;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset, flush, is_alu_op, is_ld_op, ld_valid, rs1_used, rs2_used;
  logic [AW-1:0] alu_rd, ld_rd, rs1, rs2;
  logic          fetch_stall, reg_we, wb_sel, lsu_en, alu_ack, ld_ack, ld_fwd;
  logic [AW-1:0] reg_waddr;
  logic [1:0]    ld_pending, dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef PIPE_CTRL_LD_FWD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  pipe_ctrl #(.REG_ADDR_W(AW), .MAX_LD(2), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .is_alu_op(is_alu_op), .alu_rd(alu_rd),
    .is_ld_op(is_ld_op), .ld_rd(ld_rd), .ld_valid(ld_valid),
    .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .fetch_stall(fetch_stall), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .wb_sel(wb_sel), .lsu_en(lsu_en), .alu_ack(alu_ack), .ld_ack(ld_ack),
    .ld_fwd(ld_fwd), .ld_pending(ld_pending), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and return all inputs to idle.
  task automatic nxt();
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; is_alu_op = 1'b0; is_ld_op = 1'b0; ld_valid = 1'b0;
    rs1_used = 1'b0; rs2_used = 1'b0; alu_rd = '0; ld_rd = '0; rs1 = '0; rs2 = '0;
  endtask

  initial begin
    nxt(); reset = 1'b1;
    nxt(); reset = 1'b1; is_alu_op = 1'b1; alu_rd = 5'd7; is_ld_op = 1'b1; ld_rd = 5'd3; #1;
    chk("rst_reg_we", reg_we, 0);
    chk("rst_lsu_en", lsu_en, 0);
    chk("rst_ld_ack", ld_ack, 0);
    chk("rst_alu_ack", alu_ack, 0);
    chk("rst_stall", fetch_stall, 0);
    nxt(); #1;
    chk("post_rst_pending", ld_pending, 0);
    chk("post_rst_state", dbg_state, 0);
    chk("post_rst_lsu_en", lsu_en, 1);

    // Writes to x0 are suppressed and x0 sources never stall.
    nxt(); is_alu_op = 1'b1; alu_rd = 5'd0; rs1 = 5'd0; rs1_used = 1'b1; #1;
    chk("x0_alu_we", reg_we, 0);
    chk("x0_rs_stall", fetch_stall, 0);
    nxt(); is_alu_op = 1'b1; alu_rd = 5'd9; #1;
    chk("alu_we", reg_we, 1);
    chk("alu_waddr", reg_waddr, 9);
    chk("alu_sel", wb_sel, 0);
    chk("alu_ack", alu_ack, 1);

    // Load-use on x5.
    nxt(); is_ld_op = 1'b1; ld_rd = 5'd5; #1;
    chk("lu_ack", ld_ack, 1);
    nxt(); rs1 = 5'd5; rs1_used = 1'b1; #1;
    chk("lu_stall1", fetch_stall, 1);
    chk("lu_pending", ld_pending, 1);
    nxt(); rs1 = 5'd5; rs1_used = 1'b1; #1;
    chk("lu_stall2", fetch_stall, 1);
    nxt(); rs1 = 5'd5; rs1_used = 1'b1; ld_valid = 1'b1; #1;
    chk("lu_ret_we", reg_we, 1);
    chk("lu_ret_waddr", reg_waddr, 5);
    chk("lu_ret_sel", wb_sel, 1);
    chk("lu_ret_stall", fetch_stall, !FWD);
    chk("lu_ret_fwd", ld_fwd, FWD);
    nxt(); rs1 = 5'd5; rs1_used = 1'b1; #1;
    chk("lu_after_stall", fetch_stall, 0);
    chk("lu_after_pending", ld_pending, 0);

    // FIFO full with MAX_LD=2.
    nxt(); is_ld_op = 1'b1; ld_rd = 5'd1; #1;
    chk("full_ack1", ld_ack, 1);
    nxt(); is_ld_op = 1'b1; ld_rd = 5'd2; #1;
    chk("full_ack2", ld_ack, 1);
    nxt(); is_ld_op = 1'b1; ld_rd = 5'd4; #1;
    chk("full_ack3", ld_ack, 0);
    chk("full_stall3", fetch_stall, 1);
    chk("full_pending", ld_pending, 2);
    nxt(); is_ld_op = 1'b1; ld_rd = 5'd6; ld_valid = 1'b1; #1;
    chk("full_swap_ack", ld_ack, 1);
    chk("full_swap_waddr", reg_waddr, 1);
    chk("full_swap_stall", fetch_stall, 0);
    nxt(); rs2 = 5'd6; rs2_used = 1'b1; #1;
    chk("full_after_pending", ld_pending, 2);
    chk("raw_young_stall", fetch_stall, 1);
    nxt(); ld_valid = 1'b1; #1;
    chk("drain_waddr2", reg_waddr, 2);
    nxt(); ld_valid = 1'b1; #1;
    chk("drain_waddr6", reg_waddr, 6);

    // ALU/load writeback collision.
    nxt(); is_ld_op = 1'b1; ld_rd = 5'd3; #1;
    chk("col_ld_ack", ld_ack, 1);
    nxt(); is_alu_op = 1'b1; alu_rd = 5'd7; ld_valid = 1'b1; #1;
    chk("col_waddr", reg_waddr, 3);
    chk("col_sel", wb_sel, 1);
    chk("col_alu_ack", alu_ack, 0);
    chk("col_stall", fetch_stall, 1);
    nxt(); is_alu_op = 1'b1; alu_rd = 5'd7; #1;
    chk("col2_waddr", reg_waddr, 7);
    chk("col2_sel", wb_sel, 0);
    chk("col2_alu_ack", alu_ack, 1);

    // Load to x0 returns without a write.
    nxt(); is_ld_op = 1'b1; ld_rd = 5'd0; #1;
    chk("x0_ld_ack", ld_ack, 1);
    nxt(); ld_valid = 1'b1; #1;
    chk("x0_ld_we", reg_we, 0);
    nxt(); #1;
    chk("x0_ld_pending", ld_pending, 0);

    // Return with nothing outstanding is ignored.
    nxt(); ld_valid = 1'b1; #1;
    chk("orphan_we", reg_we, 0);
    nxt(); #1;
    chk("orphan_pending", ld_pending, 0);

    // Flush with two loads outstanding: DRAIN, then three bubble cycles.
    nxt(); is_ld_op = 1'b1; ld_rd = 5'd10;
    nxt(); is_ld_op = 1'b1; ld_rd = 5'd11;
    nxt(); flush = 1'b1; is_ld_op = 1'b1; ld_rd = 5'd12; #1;
    chk("fl_lsu_en", lsu_en, 0);
    chk("fl_ld_ack", ld_ack, 0);
    nxt(); #1;
    chk("fl_state_drain", dbg_state, 1);
    chk("fl_drain_stall", fetch_stall, 1);
    chk("fl_drain_pending", ld_pending, 2);
    nxt(); ld_valid = 1'b1; #1;
    chk("fl_kill1_we", reg_we, 0);
    nxt(); ld_valid = 1'b1; #1;
    chk("fl_kill2_we", reg_we, 0);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("fl_bubble_state", dbg_state, 2);
      chk("fl_bubble_stall", fetch_stall, 1);
    end
    nxt(); #1;
    chk("fl_run_state", dbg_state, 0);
    chk("fl_run_stall", fetch_stall, 0);

    // Flush in BUBBLE restarts the count.
    nxt(); flush = 1'b1;
    nxt(); flush = 1'b1; #1;
    chk("rb_state1", dbg_state, 2);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("rb_bubble", dbg_state, 2);
    end
    nxt(); #1;
    chk("rb_run", dbg_state, 0);

    // Reset in the middle of DRAIN.
    nxt(); is_ld_op = 1'b1; ld_rd = 5'd12;
    nxt(); flush = 1'b1;
    nxt(); #1;
    chk("rd_state_drain", dbg_state, 1);
    nxt(); reset = 1'b1; is_alu_op = 1'b1; alu_rd = 5'd8; ld_valid = 1'b1; #1;
    chk("rd_rst_stall", fetch_stall, 0);
    chk("rd_rst_we", reg_we, 0);
    chk("rd_rst_pending", ld_pending, 0);
    nxt(); #1;
    chk("rd_state_run", dbg_state, 0);
    chk("rd_pending", ld_pending, 0);
    chk("rd_lsu_en", lsu_en, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
